// File: rtl/window_feeder_pkg.sv
// window_feeder_pkg
//   Shared constants for the window feeder and its consumers: the multiply-add
//   tree width (one byte lane per kernel tap), the pixel width and the default
//   image geometry. Also provides a helper that gives the number of valid
//   windows per frame.
package window_feeder_pkg;

  // Number of byte lanes in the mult_adder tree; must equal KERNEL_SIZE^2.
  localparam int MA_TREE_SIZE    = 16;
  localparam int PIXEL_WIDTH     = 8;
  localparam int DEF_IMG_WIDTH   = 8;
  localparam int DEF_IMG_HEIGHT  = 8;
  localparam int DEF_KERNEL_SIZE = 4;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  // Valid KxK windows in a w x h frame (no padding, stride 1).
  function automatic int windows_per_frame(input int w, input int h, input int k);
    return (h - k + 1) * (w - k + 1);
  endfunction

endpackage

// File: rtl/window_feeder_line_buffer.sv
// window_feeder_line_buffer
//   One image row of pixel storage, addressed by column. The read port is
//   combinational on the same address as the write port, so a read in the
//   accepting cycle returns the value stored one row earlier (read-before-write).
//   Contents are not reset; the feeder never presents them before overwriting.
// Ports:
//   clock    - rising-edge clock
//   wr_en_i  - write the current address this cycle
//   addr_i   - column address
//   wdata_i  - pixel to store
//   rdata_o  - pixel currently stored at addr_i
module window_feeder_line_buffer #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_feeder.sv
// window_feeder
//   Turns a raster-order pixel stream into the stream of every valid KxK
//   window, packed for the mult_adder operand. K-1 line buffers supply the
//   older rows of the current column; a KxK register window shifts left by one
//   column on every accepted pixel.
//   Packing: byte k = r*K + c, r=0 top row, c=0 left column; byte K*K-1 is the
//   newest pixel.
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous active-high reset
//   in_pixel    - raster pixel
//   in_valid    - in_pixel valid
//   in_ready    - pixel accepted when in_valid && in_ready
//   out_window  - packed KxK window
//   out_valid   - out_window valid
//   out_ready   - consumer takes the window
//   out_last    - marks the final window of the frame
//   frame_done  - one-cycle pulse after the last pixel of a frame is accepted
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int IMG_WIDTH   = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEF_IMG_HEIGHT,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int PIXEL_W     = PIXEL_WIDTH
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [PIXEL_W-1:0]                     in_pixel,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [PIXEL_W*KERNEL_SIZE*KERNEL_SIZE-1:0] out_window,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   frame_done
);

  localparam int K  = KERNEL_SIZE;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic frame_done_q, frame_done_d;

  logic [PIXEL_W-1:0] win_q [K][K];
  logic [PIXEL_W-1:0] win_d [K][K];

  logic [PIXEL_W-1:0] lb_rd [K-1];
  logic [PIXEL_W-1:0] lb_wd [K-1];
  logic [PIXEL_W-1:0] new_col [K];

  logic accept;
  logic win_fire;
  logic frame_end;

  // Back-pressure is purely combinational: a presented window must be taken
  // (or absent) before another pixel may enter, so out_window never changes
  // under a stalled consumer.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
  // Requiring col >= K-1 keeps windows from straddling a row boundary.
  assign win_fire  = accept && (row_q >= ROW_KM1) && (col_q >= COL_KM1);

  // Line buffer chain: lb[0] holds the previous row, lb[i] the row i+1 above.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      assign lb_wd[i] = in_pixel;
    end else begin : g_rest
      assign lb_wd[i] = lb_rd[i-1];
    end

    window_feeder_line_buffer #(
      .DEPTH (IMG_WIDTH),
      .W     (PIXEL_W),
      .AW    (CW)
    ) u_lb (
      .clock   (clock),
      .wr_en_i (accept),
      .addr_i  (col_q),
      .wdata_i (lb_wd[i]),
      .rdata_o (lb_rd[i])
    );
  end

  // Incoming right-hand column, top (oldest row) to bottom (new pixel).
  for (genvar r = 0; r < K; r++) begin : g_col
    if (r == K - 1) begin : g_bottom
      assign new_col[r] = in_pixel;
    end else begin : g_upper
      assign new_col[r] = lb_rd[K-2-r];
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    frame_done_d = 1'b0;
    if (accept) begin
      // An accept implies any presented window is consumed this cycle.
      out_valid_d  = win_fire;
      frame_done_d = frame_end;
      if (win_fire) begin
        out_last_d = frame_end;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = new_col[r];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_pack_r
    for (genvar c = 0; c < K; c++) begin : g_pack_c
      assign out_window[(r*K+c)*PIXEL_W +: PIXEL_W] = win_q[r][c];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder
//   Drives ramp, constant and random frames with random valid/ready patterns
//   and compares the window stream against a frame-array reference model.
module tb_window_feeder;
  import window_feeder_pkg::*;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 4;
  localparam int PW = 8;
  localparam int WB = PW * K * K;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] in_pixel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WB-1:0] out_window;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          frame_done;

  always #5 clock = ~clock;

  window_feeder #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .KERNEL_SIZE (K),
    .PIXEL_W     (PW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_pixel   (in_pixel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the pixels of the current frame by position, and the
  // windows that have been produced but not yet consumed.
  typedef struct {
    logic [WB-1:0] win;
    logic          last;
  } exp_t;

  exp_t          expq[$];
  logic [PW-1:0] img [H][W];
  int            mr = 0, mc = 0;
  logic          exp_fd = 1'b0;
  int            win_cnt = 0;
  bit            const_mode = 0;
  logic [WB-1:0] first_win = '0, last_win = '0;

  task automatic model_accept(input logic [PW-1:0] px);
    exp_t e;
    img[mr][mc] = px;
    if (mr >= K - 1 && mc >= K - 1) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          e.win[(i*K+j)*PW +: PW] = img[mr-K+1+i][mc-K+1+j];
      e.last = (mr == H - 1) && (mc == W - 1);
      expq.push_back(e);
    end
    exp_fd = (mr == H - 1) && (mc == W - 1);
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endtask

  task automatic cycle(input logic v, input logic [PW-1:0] px, input logic rdy, output logic acc);
    exp_t e;
    int   dot;
    @(negedge clock);
    reset     = 1'b0;
    in_valid  = v;
    in_pixel  = px;
    out_ready = rdy;
    #1;
    chk("out_valid", out_valid, expq.size() != 0);
    chk("in_ready", in_ready, (expq.size() == 0) || rdy);
    chk("frame_done", frame_done, exp_fd);
    if (out_valid && expq.size() != 0) begin
      chk("window", out_window, expq[0].win);
      chk("out_last", out_last, expq[0].last);
      if (rdy) begin
        e = expq.pop_front();
        win_cnt++;
        if (win_cnt == 1) first_win = out_window;
        if (const_mode) begin
          dot = 0;
          for (int k = 0; k < K * K; k++) dot += int'(out_window[k*PW +: PW]) * 2;
          chk("ma_dot", dot, 96);
        end
        if (e.last) begin
          chk("win_count", win_cnt, windows_per_frame(W, H, K));
          last_win = out_window;
          win_cnt  = 0;
        end
      end
    end
    acc    = v && in_ready;
    exp_fd = 1'b0;
    if (acc) model_accept(px);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_window", out_window, 0);
    expq.delete();
    mr = 0; mc = 0; exp_fd = 1'b0; win_cnt = 0;
  endtask

  // mode 0: ramp base+index, 1: random pixels, 2: constant 3
  task automatic feed(input int base, input int start, input int count, input int mode,
                      input int pv, input int rdy);
    int            n = start;
    int            guard = 0;
    logic          acc, v, r;
    logic [PW-1:0] px;
    while (n < start + count && guard < 4000) begin
      v = ($urandom_range(99) < pv);
      r = ($urandom_range(99) < rdy);
      case (mode)
        0:       px = PW'(base + n);
        1:       px = PW'($urandom);
        default: px = PW'(3);
      endcase
      cycle(v, px, r, acc);
      if (acc) n++;
      guard++;
    end
    if (guard >= 4000) chk("feed_timeout", 0, 1);
  endtask

  task automatic drain();
    int   guard = 0;
    logic acc;
    while (expq.size() != 0 && guard < 50) begin
      cycle(1'b0, '0, 1'b1, acc);
      guard++;
    end
    if (expq.size() != 0) chk("drain_timeout", 0, 1);
    cycle(1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    do_reset();

    // Continuous ramp frame.
    feed(0, 0, W * H, 0, 100, 100);
    drain();
    chk("first_b0", first_win[0*8 +: 8], 0);
    chk("first_b1", first_win[1*8 +: 8], 1);
    chk("first_b3", first_win[3*8 +: 8], 3);
    chk("first_b4", first_win[4*8 +: 8], 8);
    chk("first_b15", first_win[15*8 +: 8], 27);
    chk("last_b0", last_win[0*8 +: 8], 36);
    chk("last_b15", last_win[15*8 +: 8], 63);

    // Three stalled cycles while a window is presented.
    feed(0, 0, 30, 0, 100, 100);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, PW'(30), 1'b0, acc);
      chk("stall_accept", acc, 0);
    end
    feed(0, 30, W * H - 30, 0, 100, 100);
    drain();

    // Reset mid-frame, then a full ramp again.
    feed(0, 0, 21, 0, 100, 100);
    do_reset();
    feed(0, 0, W * H, 0, 100, 100);
    drain();
    chk("rerun_first_b15", first_win[15*8 +: 8], 27);

    // Back-to-back frames, the second offset by 100.
    feed(0, 0, W * H, 0, 100, 100);
    feed(100, 0, W * H, 0, 100, 100);
    drain();
    chk("f2_first_b0", first_win[0*8 +: 8], 100);
    chk("f2_first_b15", first_win[15*8 +: 8], 127);
    chk("f2_last_b15", last_win[15*8 +: 8], 163);

    // Constant image into a kernel of all 2s.
    const_mode = 1;
    feed(0, 0, W * H, 2, 100, 100);
    drain();
    const_mode = 0;

    // Random pixels with random valid/ready.
    for (int f = 0; f < 3; f++) feed(0, 0, W * H, 1, 70, 60);
    drain();
    feed(0, 0, 37, 1, 80, 50);
    do_reset();
    feed(0, 0, W * H, 1, 90, 40);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
